// File: rtl/uart_word_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_word_rx_pkg
//   Shared definitions for the oversampled UART word receiver:
//     - receive FSM state encoding
//     - oversampling / majority-vote sample positions
//     - byte-count width
//     - helpers that derive the tick divider and its counter width
//   The transmit side reuses baud_div/div_width so both directions agree on
//   the tick period for a given FREQ/BAUD pair.
// -----------------------------------------------------------------------------
package uart_word_rx_pkg;

    // Receive FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // Sub-tick counter covers one bit period of 16 ticks.
    localparam int unsigned SUB_W = 4;

    // Sub-tick positions of the three majority-vote samples; the bit value
    // is decided on the tick of the last one.
    localparam logic [SUB_W-1:0] SAMPLE_A = 4'd7;
    localparam logic [SUB_W-1:0] SAMPLE_B = 4'd8;
    localparam logic [SUB_W-1:0] SAMPLE_C = 4'd9;

    // byte_count port width; supports up to 8 bytes per word.
    localparam int unsigned COUNT_W = 3;

    // Clocks per oversampling tick, truncated.
    function automatic int unsigned baud_div(input int unsigned freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return freq / (baud * oversample);
    endfunction

    // Width of a counter running 0..div-1 (at least one bit).
    function automatic int unsigned div_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Two-out-of-three vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Divider value at the default 12 MHz / 9600 baud / 16x operating point.
    localparam int unsigned DEFAULT_DIV = baud_div(12000000, 9600, 16);

endpackage

// File: rtl/uart_word_rx_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Oversampling tick generator. A counter runs 0..DIV-1 and tick is high for
//   the single clock in which the counter sits at DIV-1, giving one pulse
//   every DIV clocks. While clear is high the counter is held at 0 and tick
//   is suppressed, so releasing clear restarts the tick phase from scratch.
//
// Ports
//   clk    in  1  system clock
//   nrst   in  1  synchronous active-low reset
//   clear  in  1  hold counter at 0, no ticks
//   tick   out 1  one-clock pulse every DIV clocks
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_word_rx_pkg::*;
#(
    parameter int unsigned DIV = 78
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = div_width(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nrst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_word_rx.sv
// -----------------------------------------------------------------------------
// uart_word_rx
//   Oversampled 8N1 UART receiver that packs BYTES received bytes into one
//   word (first byte in the MSBs) and presents it on a valid/ready output.
//   rx is synchronised by two flops, each bit is sampled three times around
//   its centre (sub-ticks 7, 8, 9 of 16) and decided by majority vote.
//
// Ports
//   clk         in   1   system clock
//   nrst        in   1   synchronous active-low reset
//   rx          in   1   asynchronous serial input, idle high
//   word_out    out  W   assembled word (W = 8*BYTES)
//   word_valid  out  1   word_out holds an unconsumed word
//   word_ready  in   1   downstream accepts the word
//   byte_count  out  3   bytes held in the current partial word
//   busy        out  1   receive FSM not idle
//   frame_err   out  1   one-clock pulse: stop bit sampled low
//   overrun     out  1   one-clock pulse: completed word dropped
//
// Output handshake: a word transfers on any clock where word_valid and
// word_ready are both high. word_out never changes while word_valid is high
// except when a transfer and a new word load coincide, in which case the new
// word replaces the old one and word_valid stays high. word_ready with
// word_valid low is ignored.
// -----------------------------------------------------------------------------
module uart_word_rx
    import uart_word_rx_pkg::*;
#(
    parameter int unsigned FREQ       = 12000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned BYTES      = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               rx,
    output logic [8*BYTES-1:0] word_out,
    output logic               word_valid,
    input  logic               word_ready,
    output logic [2:0]         byte_count,
    output logic               busy,
    output logic               frame_err,
    output logic               overrun
);

    localparam int unsigned W   = 8 * BYTES;
    localparam int unsigned DIV = baud_div(FREQ, BAUD, OVERSAMPLE);
    localparam logic [COUNT_W-1:0] LAST_BYTE = COUNT_W'(BYTES - 1);

    // ---------------------------------------------------------------------
    // rx synchroniser; reset to the idle (high) line level.
    // ---------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // ---------------------------------------------------------------------
    // Tick generator: free-running only while a frame is being sampled, so
    // every frame starts with the tick phase aligned to its start edge.
    // ---------------------------------------------------------------------
    rx_state_t state;
    rx_state_t state_next;
    logic      tick;
    logic      tick_clear;

    assign tick_clear = (state == ST_IDLE) || (state == ST_BREAK);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk  (clk),
        .nrst (nrst),
        .clear(tick_clear),
        .tick (tick)
    );

    // ---------------------------------------------------------------------
    // Sub-tick counter, majority sampler and data shift register.
    // ---------------------------------------------------------------------
    logic [SUB_W-1:0] st;
    logic [2:0]       bit_idx;
    logic             samp_a;
    logic             samp_b;
    logic [7:0]       rx_byte;
    logic             decide;
    logic             bit_val;

    // The third sample is the live rxs value on the deciding tick.
    assign decide  = tick && (st == SAMPLE_C);
    assign bit_val = maj3(samp_a, samp_b, rxs);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state. State changes happen on the deciding tick, i.e. in
    // the middle of a bit; st keeps counting through the rest of that bit,
    // so the next decision lands in the middle of the following bit.
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!rxs) state_next = ST_START;
            end
            ST_START: begin
                // A start bit that reads high at its centre was a glitch.
                if (decide) state_next = bit_val ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide && (bit_idx == 3'd7)) state_next = ST_STOP;
            end
            ST_STOP: begin
                // Returning to IDLE mid-stop-bit lets the next start edge be
                // seen as early as possible.
                if (decide) state_next = bit_val ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                if (rxs) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs / datapath strobes
    // ---------------------------------------------------------------------
    logic shift_en;
    logic byte_done;
    logic stop_bad;

    always_comb begin
        busy      = (state != ST_IDLE);
        shift_en  = (state == ST_DATA) && decide;
        byte_done = (state == ST_STOP) && decide && bit_val;
        stop_bad  = (state == ST_STOP) && decide && !bit_val;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            st      <= '0;
            bit_idx <= '0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
            rx_byte <= '0;
        end else if (state == ST_IDLE) begin
            st      <= '0;
            bit_idx <= '0;
        end else if (tick) begin
            // 4-bit counter: 15 rolls over to 0 at the bit boundary.
            st <= st + 1'b1;
            if (st == SAMPLE_A) samp_a <= rxs;
            if (st == SAMPLE_B) samp_b <= rxs;
            if (shift_en) begin
                // LSB arrives first, so shift in from the top.
                rx_byte <= {bit_val, rx_byte[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Packer and output register.
    // ---------------------------------------------------------------------
    logic [W-1:0] asm_word;
    logic [W-1:0] asm_next;
    logic         last_byte;

    generate
        if (BYTES > 1) begin : g_multi
            assign asm_next = {asm_word[W-9:0], rx_byte};
        end else begin : g_single
            assign asm_next = rx_byte;
        end
    endgenerate

    assign last_byte = (byte_count == LAST_BYTE);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            asm_word   <= '0;
            byte_count <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= 1'b0;

            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            // Frame errors leave the partial word untouched.
            if (byte_done) begin
                asm_word <= asm_next;
                if (last_byte) begin
                    byte_count <= '0;
                    // Loading wins over the clear above when both happen.
                    if (!word_valid || word_ready) begin
                        word_out   <= asm_next;
                        word_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    byte_count <= byte_count + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_word_rx
//   Self-checking bench for uart_word_rx. The line rate is set so that one
//   bit lasts 64 clocks (DIV = 4) to keep frames short. Expected words,
//   byte counts and flag counts come from a byte-level model of the framing
//   and packing rules; every comparison goes through check_eq.
// -----------------------------------------------------------------------------
module tb_uart_word_rx;

    localparam int unsigned FREQ    = 12000000;
    localparam int unsigned BAUD    = 187500;
    localparam int unsigned BYTES   = 4;
    localparam int unsigned W       = 8 * BYTES;
    localparam int          BIT_CLK = FREQ / BAUD;
    localparam int          GAP     = 20;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         rx = 1'b1;
    logic         fixed_ready = 1'b1;
    logic         rnd_ready = 1'b1;
    logic         rand_ready = 1'b0;
    logic         word_ready;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic [2:0]   byte_count;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    assign word_ready = rand_ready ? rnd_ready : fixed_ready;

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    uart_word_rx #(
        .FREQ(FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .BYTES(BYTES)
    ) dut (
        .clk(clk), .nrst(nrst), .rx(rx),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .byte_count(byte_count), .busy(busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_partial = '0;
    int           m_cnt = 0;
    bit           m_slot_full = 1'b0;
    int           exp_ferr = 0;
    int           exp_ovr = 0;
    int           seen_ferr = 0;
    int           seen_ovr = 0;
    int           rise_cyc = 0;
    int           frame_start = 0;

    task automatic model_accept(input logic [7:0] b);
        m_partial = {m_partial[W-9:0], b};
        m_cnt++;
        if (m_cnt == BYTES) begin
            m_cnt = 0;
            if (!m_slot_full) begin
                exp_q.push_back(m_partial);
                m_slot_full = 1'b1;
            end else begin
                exp_ovr++;
            end
        end
    endtask

    task automatic model_reset();
        m_partial = '0;
        m_cnt = 0;
        m_slot_full = 1'b0;
        exp_q.delete();
    endtask

    // Output monitor: transfers, hold-while-valid, flag pulses.
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic [W-1:0] prev_word = '0;

    initial forever begin
        @(negedge clk);
        if (nrst) begin
            if (frame_err) seen_ferr++;
            if (overrun) seen_ovr++;
            if (word_valid && !prev_valid) rise_cyc = cyc;
            if (prev_valid && !prev_ready) begin
                check_eq("word_hold", word_out, prev_word);
                check_eq("valid_hold", 32'(word_valid), 32'd1);
            end
            if (word_valid && word_ready) begin
                check_eq("word_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("word_out", word_out, exp_q.pop_front());
                m_slot_full = 1'b0;
            end
        end
        prev_valid = word_valid && nrst;
        prev_ready = word_ready;
        prev_word  = word_out;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame. glitch inverts rx for 3 clocks around the centre
    // sample of each data bit; abort_bit >= 0 pulses reset inside that bit
    // and ends the frame; break_clks holds a bad stop bit low for longer.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit glitch,
                              input int abort_bit, input int break_clks);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        frame_start = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                if (stop_ok) model_accept(b);
                else exp_ferr++;
            end
            rx = bits[i];
            if (i == abort_bit) begin
                wait_clk(BIT_CLK / 2);
                nrst = 1'b0;
                rx = 1'b1;
                wait_clk(1);
                model_reset();
                check_eq("rst_word_out", word_out, 32'd0);
                check_eq("rst_word_valid", 32'(word_valid), 32'd0);
                check_eq("rst_byte_count", 32'(byte_count), 32'd0);
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_frame_err", 32'(frame_err), 32'd0);
                check_eq("rst_overrun", 32'(overrun), 32'd0);
                nrst = 1'b1;
                wait_clk(3 * BIT_CLK);
                return;
            end
            if (glitch && i >= 1 && i <= 8) begin
                wait_clk(35);
                rx = ~bits[i];
                wait_clk(3);
                rx = bits[i];
                wait_clk(BIT_CLK - 38);
            end else begin
                wait_clk(BIT_CLK);
            end
        end
        if (break_clks > 0) begin
            wait_clk(break_clks);
            check_eq("break_busy", 32'(busy), 32'd1);
        end
        rx = 1'b1;
        wait_clk(GAP);
        check_eq("byte_count", 32'(byte_count), 32'(m_cnt));
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b0, -1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] t1_bytes[4];
        t1_bytes = '{8'h53, 8'h6E, 8'h61, 8'h70};

        nrst = 1'b0;
        wait_clk(5);
        check_eq("reset_word_out", word_out, 32'd0);
        check_eq("reset_word_valid", 32'(word_valid), 32'd0);
        check_eq("reset_byte_count", 32'(byte_count), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_frame_err", 32'(frame_err), 32'd0);
        check_eq("reset_overrun", 32'(overrun), 32'd0);
        nrst = 1'b1;
        wait_clk(10);

        // T1: fixed word; word_valid must rise in the second half of the
        // 4th frame's stop bit.
        for (int i = 0; i < 4; i++) send_good(t1_bytes[i]);
        check_eq("t1_latency",
                 32'((rise_cyc >= frame_start + 9 * BIT_CLK + BIT_CLK / 2) &&
                     (rise_cyc <= frame_start + 10 * BIT_CLK)), 32'd1);

        // T2: short low pulse in IDLE with a partial word pending.
        send_good(8'h42);
        rx = 1'b0;
        wait_clk(25);
        rx = 1'b1;
        wait_clk(3 * BIT_CLK);
        check_eq("t2_busy", 32'(busy), 32'd0);
        check_eq("t2_byte_count", 32'(byte_count), 32'(m_cnt));

        // Random frames, some with bad stop bits, random word_ready.
        rand_ready = 1'b1;
        for (int i = 0; i < 10; i++)
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 5) != 0, 1'b0, -1, 0);
        rand_ready = 1'b0;
        fixed_ready = 1'b1;
        while (m_cnt != 0) send_good(8'($urandom_range(0, 255)));

        // T3: framing error, line held low, then a clean word.
        send_frame(8'hA5, 1'b0, 1'b0, -1, 20);
        check_eq("t3_busy_after", 32'(busy), 32'd0);
        for (int i = 1; i <= 4; i++) send_good(8'(i));

        // T4: downstream stalled for two words.
        fixed_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_good(8'($urandom_range(0, 255)));
            if (i == 3) begin
                check_eq("t4_valid", 32'(word_valid), 32'd1);
                check_eq("t4_first_word", word_out, exp_q[0]);
            end
        end
        check_eq("t4_overrun", 32'(seen_ovr), 32'(exp_ovr));
        check_eq("t4_held_word", word_out, exp_q[0]);
        fixed_ready = 1'b1;
        wait_clk(3);
        check_eq("t4_valid_fall", 32'(word_valid), 32'd0);
        check_eq("t4_queue", 32'(exp_q.size()), 32'd0);

        // T5: narrow glitches on the centre sample of each data bit.
        send_frame(8'h3C, 1'b1, 1'b1, -1, 0);
        for (int i = 0; i < 3; i++) send_good(8'($urandom_range(0, 255)));

        // T6: reset in the middle of the 2nd byte, then a clean word.
        send_good(8'h11);
        send_frame(8'h22, 1'b1, 1'b0, 4, 0);
        for (int i = 0; i < 4; i++) send_good(8'($urandom_range(0, 255)));

        wait_clk(50);
        check_eq("frame_err_count", 32'(seen_ferr), 32'(exp_ferr));
        check_eq("overrun_count", 32'(seen_ovr), 32'(exp_ovr));
        check_eq("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
